// File: rtl/iter_divider_if.sv
// Handshake and operand/result bundle between a pipeline controller and the
// iterative 32-bit divider.
interface iter_divider_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    // Controller side: issues requests, consumes results.
    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side: accepts requests, produces results.
    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iter_divider.sv
// Iterative restoring divider for DIV / DIVU.
// One quotient bit per clock over 32 CALC cycles, then a DONE cycle that
// applies sign correction and publishes quotient (LO) / remainder (HI).
// Results are held until the next operation completes.
module iter_divider (
    input  logic             clk,
    input  logic             reset,
    iter_divider_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [32:0] rem_r;          // partial remainder, 33 bits wide
    logic [31:0] dvd_r;          // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] dsr_mag_r;      // divisor magnitude
    logic [31:0] dvd_raw_r;      // dividend as latched, returned on divide by zero
    logic        q_neg_r;        // operand signs differ (signed mode only)
    logic        r_neg_r;        // dividend negative (signed mode only)
    logic        dsr_zero_r;

    logic        busy_r;
    logic        done_r;
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;
    logic        div_by_zero_r;

    logic [33:0] shifted_s;
    logic [33:0] trial_s;
    logic [32:0] rem_next_s;
    logic        q_bit_s;
    logic [31:0] q_final_s;
    logic [31:0] r_final_s;

    // Two's complement negation when requested, pass-through otherwise.
    function automatic logic [31:0] cond_negate(input logic [31:0] x, input logic neg);
        logic [31:0] res;
        if (neg) begin
            res = (~x) + 32'd1;
        end else begin
            res = x;
        end
        return res;
    endfunction

    // One restoring step: shift in the next dividend bit and try a subtract.
    always_comb begin
        shifted_s  = {rem_r, dvd_r[31]};
        trial_s    = shifted_s - {2'b00, dsr_mag_r};
        rem_next_s = shifted_s[32:0];
        q_bit_s    = 1'b0;
        if (trial_s[33] == 1'b0) begin
            rem_next_s = trial_s[32:0];
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = shifted_s[32:0];
            q_bit_s    = 1'b0;
        end
    end

    // Final result selection: divide-by-zero override, else sign correction.
    always_comb begin
        q_final_s = 32'd0;
        r_final_s = 32'd0;
        if (dsr_zero_r) begin
            q_final_s = 32'hFFFF_FFFF;
            r_final_s = dvd_raw_r;
        end else begin
            q_final_s = cond_negate(dvd_r, q_neg_r);
            r_final_s = cond_negate(rem_r[31:0], r_neg_r);
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 5'd0;
            rem_r         <= 33'd0;
            dvd_r         <= 32'd0;
            dsr_mag_r     <= 32'd0;
            dvd_raw_r     <= 32'd0;
            q_neg_r       <= 1'b0;
            r_neg_r       <= 1'b0;
            dsr_zero_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= 32'd0;
            remainder_r   <= 32'd0;
            div_by_zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        dvd_r      <= cond_negate(bus.dividend, bus.is_signed & bus.dividend[31]);
                        dsr_mag_r  <= cond_negate(bus.divisor,  bus.is_signed & bus.divisor[31]);
                        dvd_raw_r  <= bus.dividend;
                        q_neg_r    <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
                        r_neg_r    <= bus.is_signed & bus.dividend[31];
                        dsr_zero_r <= (bus.divisor == 32'd0);
                        rem_r      <= 33'd0;
                        cnt_r      <= 5'd0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_CALC;
                    end else begin
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[30:0], q_bit_s};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    quotient_r    <= q_final_s;
                    remainder_r   <= r_final_s;
                    div_by_zero_r <= dsr_zero_r;
                    done_r        <= 1'b1;
                    busy_r        <= 1'b0;
                    cnt_r         <= 5'd0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    cnt_r   <= 5'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider.
module tb_iter_divider;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    iter_divider_if dif ();

    iter_divider u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request before an edge; returns #1 after the accepting edge E0.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.start     = 1'b1;
        dif.is_signed = sgn;
        dif.dividend  = a;
        dif.divisor   = b;
        @(posedge clk);
        #1;
        dif.start     = 1'b0;
    endtask

    // Wait for done; lat is the number of edges after E0 (already = edges consumed so far).
    task automatic wait_done(input int already, output int lat);
        lat = -1;
        for (int i = already + 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Full operation with latency, result and single-cycle done checks.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_z);
        int lat;
        issue(sgn, a, b);
        check({tag, "_busy"}, {31'd0, dif.busy}, 32'd1);
        wait_done(0, lat);
        check({tag, "_lat"}, lat, 32'd33);
        check({tag, "_q"}, dif.quotient, exp_q);
        check({tag, "_r"}, dif.remainder, exp_r);
        check({tag, "_dbz"}, {31'd0, dif.div_by_zero}, {31'd0, exp_z});
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, dif.done}, 32'd0);
    endtask

    initial begin
        int lat;
        int done_seen;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = 32'd0;
        dif.divisor   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_done", {31'd0, dif.done}, 32'd0);
        check("rst_q", dif.quotient, 32'd0);
        check("rst_r", dif.remainder, 32'd0);
        check("rst_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, 1'b0);
        run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        run_op("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 1'b0);
        run_op("divu_ovfops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_big",     1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001, 32'h7FFF_FFFE, 1'b0);
        run_op("divu_z",       1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

        // Results and the zero flag hold while the next op is computing.
        issue(1'b1, 32'hFFFF_FF9C, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_q", dif.quotient, 32'hFFFF_FFFF);
        check("hold_r", dif.remainder, 32'h1234_5678);
        check("hold_dbz", {31'd0, dif.div_by_zero}, 32'd1);
        wait_done(5, lat);
        check("div_z_lat", lat, 32'd33);
        check("div_z_q", dif.quotient, 32'hFFFF_FFFF);
        check("div_z_r", dif.remainder, 32'hFFFF_FF9C);
        check("div_z_dbz", {31'd0, dif.div_by_zero}, 32'd1);

        // A start in the middle of CALC is ignored.
        issue(1'b0, 32'd1000, 32'd33);
        repeat (10) @(posedge clk);
        #1;
        dif.start     = 1'b1;
        dif.is_signed = 1'b1;
        dif.dividend  = 32'd55;
        dif.divisor   = 32'd5;
        @(posedge clk);
        #1;
        dif.start     = 1'b0;
        check("mid_q_hold", dif.quotient, 32'hFFFF_FFFF);
        wait_done(11, lat);
        check("mid_lat", lat, 32'd33);
        check("mid_q", dif.quotient, 32'd30);
        check("mid_r", dif.remainder, 32'd10);
        check("mid_dbz", {31'd0, dif.div_by_zero}, 32'd0);

        // Reset at count 20 of an operation aborts it cleanly.
        issue(1'b0, 32'd5000, 32'd7);
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("ar_busy", {31'd0, dif.busy}, 32'd0);
        check("ar_done", {31'd0, dif.done}, 32'd0);
        check("ar_q", dif.quotient, 32'd0);
        check("ar_r", dif.remainder, 32'd0);
        check("ar_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1) done_seen++;
        end
        check("ar_no_done", done_seen, 32'd0);

        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request pulse from the controller; accepted only in IDLE.
REQ-005 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 dividend  input  32  rs operand; sampled with start.
REQ-007 divisor  input  32  rt operand; sampled with start.
REQ-008 busy  output  1  high while in CALC.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 quotient  output  32  destined for LO.
REQ-011 remainder  output  32  destined for HI.
REQ-012 div_by_zero  output  1  set when the latched divisor is 0; valid with done and held.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL:
- latch is_signed, dividend and divisor;
- load magnitudes (|x| if signed, raw if unsigned);
- clear the 33-bit partial remainder and the 5-bit counter;
- go to CALC.
REQ-015 CALC SHALL perform one restoring step per edge:
- shift {rem, dvd} left by 1;
- trial = rem - |divisor|;
- if non-negative, rem = trial and quotient bit = 1; else quotient bit = 0.
REQ-016 The counter SHALL increment in CALC; the step taken at count 31 (the 32nd step, at edge E32) SHALL move to DONE.
REQ-017 On entering DONE, registered outputs SHALL take final values; done=1 for exactly the single DONE cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle after edge E33, i.e. 33 clocks after the accepting edge; busy SHALL be high after E0 through E32.
REQ-019 Signed correction:
- quotient is negated if the operand signs differ (truncation toward zero);
- remainder is negated if the dividend is negative.
REQ-020 Overflow: 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0, with no flag.
REQ-021 Divisor 0 SHALL still take full latency and give div_by_zero=1, quotient=0xFFFFFFFF, remainder=latched dividend (raw), for both signed and unsigned.
REQ-022 start in CALC or DONE SHALL be ignored; operands latched at E0 SHALL NOT change mid-operation.
REQ-023 quotient, remainder and div_by_zero SHALL hold their last values until the next completed operation; they SHALL NOT change during CALC.
REQ-024 Arithmetic SHALL use 33-bit remainder width to avoid loss on a divisor >= 0x80000000 in unsigned mode.

Reset
REQ-025 On reset assertion, regardless of edge or state (including mid-CALC):
- state = IDLE, counter = 0;
- busy = 0, done = 0, div_by_zero = 0;
- quotient = 0, remainder = 0.
REQ-026 After reset deassertion, the first start SHALL be accepted normally; no stale partial result SHALL appear.

Verification
REQ-027 DIVU 100 / 7 -> done exactly 33 clocks after start; quotient=0x0000000E, remainder=0x00000002, div_by_zero=0.
REQ-028 DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=0x00000001.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU same operands -> quotient=0, remainder=0x80000000.
REQ-030 DIVU 0x12345678 / 0 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x12345678, done after 33 clocks.
REQ-031 start with new operands at count 10 of CALC -> ignored, result equals the original operation's; then reset asserted at count 20 of a second op -> busy=0, outputs 0, no done pulse; a subsequent DIVU 9 / 3 -> quotient=3, remainder=0.
